mem_stage_bus_ctrl: RTL

- Consumer of the EX/MEM pipeline register outputs: the M-stage data-memory access controller.
- Takes the decoded M-stage load/store request (address = ALUOut_M, store data = RD2_M) and runs a req/ack transaction on a word-wide data bus.
- Drives `stall_M` back to the pipeline so the EX/MEM enable is held low until the access completes.
- Returns the aligned, sign/zero-extended load result and a completion pulse toward MEM/WB.

---
 rtl/mem_stage_bus_ctrl_pkg.sv | 21 ++
 rtl/mem_lane_align.sv | 56 +++++
 rtl/mem_stage_bus_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mem_stage_bus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mem_stage_bus_ctrl_pkg : size encodings, FSM states and default bus timeout
// Rev 1.0
// ============================================================================
package mem_stage_bus_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// mem_lane_align : byte enables, store lane replication, load extract/extend
// Rev 1.0
// ============================================================================
module mem_lane_align
  import mem_stage_bus_ctrl_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_signed,
  input  logic [31:0] rdata,
  output logic [31:0] ld_ext
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    be        = 4'b1111;
    wdata_rep = st_data;
    case (st_size)
      SZ_BYTE: begin
        be        = 4'b0001 << st_addr_lo;
        wdata_rep = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        be        = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ld_addr_lo)
      2'd0:    w_byte = rdata[7:0];
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      default: w_byte = rdata[31:24];
    endcase
    w_half = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (ld_size)
      SZ_BYTE: ld_ext = {{24{ld_signed & w_byte[7]}}, w_byte};
      SZ_HALF: ld_ext = {{16{ld_signed & w_half[15]}}, w_half};
      default: ld_ext = rdata;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_stage_bus_ctrl.sv
`default_nettype none
// ============================================================================
// mem_stage_bus_ctrl : M-stage load/store req/ack bus controller with stall.
// Optional misaligned-access trap: define MEM_ALIGN_EXC_EN.   Rev 1.0
// ============================================================================
module mem_stage_bus_ctrl
  import mem_stage_bus_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic        m_load,
  input  logic        m_store,
  input  logic [1:0]  m_size,
  input  logic        m_signed,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall_M,
  output logic [31:0] ld_data,
  output logic        done,
  output logic        bus_err,
  output logic        align_exc
);

  localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state, w_next;
  logic        r_we, r_signed, r_bus_err, r_align_exc;
  logic [1:0]  r_size;
  logic [31:0] r_addr, r_wdata, r_ld_data;
  logic [3:0]  r_be;
  logic [7:0]  r_cnt;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ld_ext;
  logic        w_start, w_misaligned;

  assign w_start = m_valid & (m_load | m_store);

`ifdef MEM_ALIGN_EXC_EN
  assign w_misaligned = ((m_size == SZ_HALF) & m_addr[0]) |
                        ((m_size[1]) & (m_addr[1:0] != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif

  mem_lane_align u_align (
    .st_size    (m_size),
    .st_addr_lo (m_addr[1:0]),
    .st_data    (m_wdata),
    .be         (w_be),
    .wdata_rep  (w_wdata),
    .ld_size    (r_size),
    .ld_addr_lo (r_addr[1:0]),
    .ld_signed  (r_signed),
    .rdata      (bus_rdata),
    .ld_ext     (w_ld_ext)
  );

  always_comb begin
    w_next  = r_state;
    stall_M = 1'b0;
    case (r_state)
      IDLE: if (w_start) begin
        stall_M = 1'b1;
        w_next  = w_misaligned ? DONE : REQ;
      end
      REQ: begin
        stall_M = 1'b1;
        if (bus_ack || (r_cnt == C_TO_LAST)) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_signed    <= 1'b0;
      r_size      <= SZ_BYTE;
      r_addr      <= '0;
      r_be        <= '0;
      r_wdata     <= '0;
      r_ld_data   <= '0;
      r_cnt       <= '0;
      r_bus_err   <= 1'b0;
      r_align_exc <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (w_start) begin
          r_we        <= m_store;
          r_signed    <= m_signed;
          r_size      <= m_size;
          r_addr      <= m_addr;
          r_be        <= w_be;
          r_wdata     <= w_wdata;
          r_cnt       <= '0;
          r_bus_err   <= 1'b0;
          r_align_exc <= w_misaligned;
          if (w_misaligned) r_ld_data <= '0;
        end
        REQ: begin
          // A store completes without touching the last load result.
          if (bus_ack) begin
            if (!r_we) r_ld_data <= w_ld_ext;
          end else if (r_cnt == C_TO_LAST) begin
            r_bus_err <= 1'b1;
            r_ld_data <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        DONE:    r_align_exc <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus_req   = (r_state == REQ);
  assign bus_we    = r_we;
  assign bus_addr  = {r_addr[31:2], 2'b00};
  assign bus_be    = r_be;
  assign bus_wdata = r_wdata;
  assign ld_data   = r_ld_data;
  assign done      = (r_state == DONE);
  assign bus_err   = r_bus_err;
  assign align_exc = r_align_exc;

endmodule
`default_nettype wire
